md_unit: RTL
============

Name: md_unit

Overview:
- E-stage multiply/divide unit with HI/LO register pair.
- Sits directly downstream of the E-stage operand forwarding muxes and consumes the forwarded operands: A is the forwarded rs value, B is the forwarded rt value.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and executes MTHI/MTLO in one cycle.
- Drives a busy flag to the hazard unit and supplies HI/LO for MFHI/MFLO, whose result is carried down the pipe with the E-stage ALU result.

Parameters:
- MULT_CYCLES, 5, busy cycles after a MULT/MULTU start (minimum 1).
- DIV_CYCLES, 10, busy cycles after a DIV/DIVU start (minimum 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- A  input  32  forwarded rs operand.
- B  input  32  forwarded rt operand.
- start  input  1  E-stage instruction is MULT/MULTU/DIV/DIVU; qualified by op.
- op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
- rd_hi  input  1  read select for out: 1 = HI, 0 = LO.
- busy  output  1  operation in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- out  output  32  rd_hi ? HI : LO (combinational, for MFHI/MFLO).

Behaviour:
- Reset (asynchronous, active-high): HI=0, LO=0, busy=0, counter=0, pending result cleared. Reset mid-operation abandons the operation; nothing commits.
- State: IDLE (busy=0) and RUN (busy=1). counter is a register wide enough for max(MULT_CYCLES, DIV_CYCLES).
- Start accept: in IDLE, start=1 with op in 1..4 is accepted. At that edge:
  - operands are sampled, the 64-bit result is computed and latched into pend_hi/pend_lo;
  - counter loads MULT_CYCLES or DIV_CYCLES;
  - state goes to RUN.
- busy therefore rises the cycle after the start cycle and stays high exactly N cycles.
- RUN: counter decrements each edge. On the edge where counter==1:
  - HI<=pend_hi, LO<=pend_lo;
  - busy<=0, state returns to IDLE.
- New results are visible on HI/LO and out in the first cycle busy is low.
- Arithmetic:
  - MULT: signed 32x32 to 64; HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32 to 64.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (DIV/DIVU with B==0): the operation still occupies DIV_CYCLES. HI/LO are left unchanged at commit; no other error is signalled.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- MTHI/MTLO: in IDLE, op 5/6 writes A into HI/LO at the edge; single cycle, busy stays 0. start is don't-care for ops 5/6.
- Any op (1..6) presented while busy=1 is ignored; HI/LO and pending state are unaffected.
- Hazard-unit contract (not implemented here): stall D when the D-stage instruction is MULT/DIV/MT/MF and (start_E | busy). Because of this stall, an ignored op indicates an upstream bug. The bench must check that it is ignored.
- start with op=0 or 7: no effect.
- out is purely combinational from HI/LO and rd_hi; zero latency.
- No flush input: a started operation always completes; E-stage bubbles present start=0.

Decomposition:
- Shared package/header: op encodings (MD_NONE..MD_MTLO), default cycle counts.
- The header already holding the pipeline's forwarding-select and Res-type defines gets these additions.
- One natural sub-module: md_compute, purely combinational, (op, A, B) -> {res_hi, res_lo, div_by_zero}. It isolates signed/unsigned arithmetic and the divide-by-zero flag. The control FSM, counter and HI/LO registers stay in md_unit.

Test Plan:
- Reset then MULT A=0xFFFFFFFE(-2), B=3:
  - busy high cycles 1..5;
  - cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
- DIVU A=7, B=0 after MTHI 0x11, MTLO 0x22:
  - MT writes visible next cycle with no busy;
  - after 10 busy cycles HI=0x11, LO=0x22 unchanged.
- MULT 3*4 started; in busy cycle 2, MTLO A=0x55 and start/DIV presented -> both ignored; final HI=0, LO=12.
- DIV started, reset asserted asynchronously in busy cycle 4:
  - busy, HI, LO = 0 immediately, with no further commit;
  - rd_hi toggling reads HI/LO combinationally.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and the control state type.
package md_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for several cycles and commit through pend_hi/pend_lo.
    function automatic logic is_start_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_unit_compute.sv
// Combinational arithmetic core: (op, a, b) -> 64-bit {res_hi, res_lo} plus
// a divide-by-zero flag. Signed divide is done on magnitudes so that the
// 0x80000000 / -1 case wraps cleanly instead of overflowing.
module md_compute
    import md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic        quot_neg;
    logic        rem_neg;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);

    assign ext_a   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign ext_b   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign product = ext_a * ext_b;

    assign mag_a   = (is_signed && a[31]) ? (32'd0 - a) : a;
    assign mag_b   = (is_signed && b[31]) ? (32'd0 - b) : b;
    // Substitute 1 for a zero divisor; the result is discarded at commit anyway.
    assign divisor = (b == 32'd0) ? 32'd1 : mag_b;
    assign uquot   = mag_a / divisor;
    assign urem    = mag_a % divisor;

    assign quot_neg = is_signed && (a[31] ^ b[31]);
    assign rem_neg  = is_signed && a[31];

    always_comb begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
        if (is_mult_op(op)) begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end else if ((op == MD_DIV) || (op == MD_DIVU)) begin
            res_lo      = quot_neg ? (32'd0 - uquot) : uquot;
            res_hi      = rem_neg ? (32'd0 - urem) : urem;
            div_by_zero = (b == 32'd0);
        end
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: accepts MULT/MULTU/DIV/DIVU, holds the result
// pending for a fixed latency, then commits to HI/LO; MTHI/MTLO write at once.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e        state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_dz;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div_by_zero;

    md_compute u_compute (
        .op          (op),
        .a           (A),
        .b           (B),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            busy    <= 1'b0;
            counter <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (state == MD_IDLE) begin
            if (start && is_start_op(op)) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_dz <= div_by_zero;
                counter <= is_mult_op(op) ? MULT_CNT : DIV_CNT;
                state   <= MD_RUN;
                busy    <= 1'b1;
            end else if (op == MD_MTHI) begin
                HI <= A;
            end else if (op == MD_MTLO) begin
                LO <= A;
            end
        end else begin
            // Every op seen while running is dropped; the hazard unit should prevent it.
            counter <= counter - CNT_ONE;
            if (counter == CNT_ONE) begin
                state <= MD_IDLE;
                busy  <= 1'b0;
                if (!pend_dz) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end
        end
    end

    assign out = rd_hi ? HI : LO;

endmodule
